mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Downstream of the coherence controller. Takes its per-cache main-bus outputs (NUM_CACHES msg/address/data channels) and serializes them onto the single main-memory port.
- Memory responses (msg, data, address) are routed back only to the granted cache. This produces the per-cache mem2cache message vector that the coherence controller and the caches consume.
- Arbitration is round-robin. A grant is held for a whole transaction, and the block inserts one idle turnaround cycle between transactions.

Parameters:
- STATUS_BITS, 2, status bits per line on the data bus
- COHERENCE_BITS, 2, coherence bits per line on the data bus
- OFFSET_BITS, 2, log2 of words per line
- DATA_WIDTH, 8, word width in bits
- ADDRESS_WIDTH, 12, address width
- MSG_BITS, 3, message field width (shared message constants from params.v)
- NUM_CACHES, 4, number of requester channels, 2..16
- TIMEOUT_CYCLES, 255, watchdog limit, used only with MEM_ARB_TIMEOUT_EN

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- cache2mem_data_in  in  NUM_CACHES*BUS_WIDTH  per-cache write data; BUS_WIDTH = STATUS_BITS+COHERENCE_BITS+DATA_WIDTH*(1<<OFFSET_BITS)
- cache2mem_address_in  in  NUM_CACHES*ADDRESS_WIDTH  per-cache address
- cache2mem_msg_in  in  NUM_CACHES*MSG_BITS  per-cache request message
- mem2cache_data_out  out  NUM_CACHES*BUS_WIDTH  per-cache read data
- mem2cache_address_out  out  NUM_CACHES*ADDRESS_WIDTH  per-cache response address
- mem2cache_msg_out  out  NUM_CACHES*MSG_BITS  per-cache response message
- mem_msg_out  out  MSG_BITS  request to memory
- mem_address_out  out  ADDRESS_WIDTH  address to memory
- mem_data_out  out  BUS_WIDTH  data to memory
- mem_msg_in  in  MSG_BITS  memory response (MEM_READY, M_RECV, REQ_FLUSH, NO_REQ)
- mem_address_in  in  ADDRESS_WIDTH  memory response address
- mem_data_in  in  BUS_WIDTH  memory read data
- grant_valid  out  1  a transaction is in progress
- grant_id  out  log2(NUM_CACHES)  index of the granted cache
- timeout_err  out  1  watchdog fired; sticky until reset

Behaviour:
- Channel i requests when its cache2mem msg slice != NO_REQ.
- Reset: state IDLE, grant_valid=0, grant_id=0, rr_ptr=0, timeout_err=0, watchdog counter=0.
- Reset values of outputs: mem_msg_out=NO_REQ, mem address/data=0, every mem2cache msg slice=NO_REQ, every mem2cache address/data slice=0.
- State IDLE:
  - If any request is present, grant the first requester at or after rr_ptr, scanning upward with wrap from NUM_CACHES-1 to 0.
  - Register grant_id, set grant_valid=1, set rr_ptr=(grant_id+1) mod NUM_CACHES, and go to GRANTED.
  - If no request is present, stay in IDLE.
- State GRANTED:
  - Memory outputs are driven combinationally from the granted channel's msg/address/data.
  - The granted channel's mem2cache slices are driven combinationally from mem_msg_in/mem_address_in/mem_data_in.
  - All other channels see NO_REQ and zeros.
- Latency: a request first sampled in cycle N appears on mem_msg_out in cycle N+1.
- Release condition: the granted channel's msg == NO_REQ and mem_msg_in != REQ_FLUSH. On release, go to RELEASE.
- A memory REQ_FLUSH holds the grant even if the cache momentarily drops to NO_REQ, so the cache's FLUSH/NO_FLUSH reply reaches memory on the same grant.
- State RELEASE (one cycle):
  - grant_valid=0, mem_msg_out=NO_REQ, all mem2cache msg slices=NO_REQ.
  - Go to IDLE unconditionally.
  - Effect: back-to-back requests from different caches see at least one NO_REQ cycle on the memory port.
- Simultaneous requests: lowest index at or after rr_ptr wins; losers keep their request asserted and wait, with no loss.
- A request that changes message mid-grant (e.g. WB_REQ followed by R_REQ) stays on the same grant until NO_REQ.
- Reset mid-transaction drops the grant immediately; the memory port sees NO_REQ on the next cycle.
- Single-requester case: the grant re-issues to the same cache after RELEASE.
- rr_ptr wraps modulo NUM_CACHES; NUM_CACHES need not be a power of two.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter increments every GRANTED cycle and clears on entry to GRANTED.
  - If it reaches TIMEOUT_CYCLES, force RELEASE and set timeout_err=1 (sticky until reset).
  - The stuck channel is not re-granted until its msg has been seen as NO_REQ for at least one cycle.
- MEM_ARB_TIMEOUT_EN undefined: no counter; timeout_err is tied to 0; the grant is held indefinitely.

Test Plan:
- Reset check: after reset, mem_msg_out=NO_REQ, grant_valid=0 and all mem2cache msgs=NO_REQ. Then cache 2 issues R_REQ at address 0x1A4 -> next cycle mem_address_out=0x1A4 and grant_id=2. Memory MEM_READY with data 0xDEADBEEF.. -> only cache 2 sees MEM_READY and the data.
- Fairness: caches 0, 1 and 3 all issue WB_REQ in the same cycle -> grants in order 0, 1, 3, each separated by one NO_REQ RELEASE cycle on the memory port.
- Wrap: rr_ptr=3, caches 0 and 3 request -> cache 3 granted first, then cache 0; rr_ptr ends at 1.
- Flush hold: memory drives REQ_FLUSH while cache 1 is granted and cache 1 drops to NO_REQ for one cycle, then sends FLUSH -> grant stays on cache 1 and FLUSH reaches memory.
- Reset mid-transaction: assert reset during GRANTED on cache 0 -> next cycle grant_valid=0 and mem_msg_out=NO_REQ; after reset release, a pending request from cache 3 is granted with rr_ptr=0.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: memory never responds -> release after 8 GRANTED cycles, timeout_err=1, and a waiting cache 2 is granted next.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serializing per-cache main-bus channels onto one memory port.
// Optional watchdog enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned STATUS_BITS    = 2,
   parameter int unsigned COHERENCE_BITS = 2,
   parameter int unsigned OFFSET_BITS    = 2,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDRESS_WIDTH  = 12,
   parameter int unsigned MSG_BITS       = 3,
   parameter int unsigned NUM_CACHES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned BUS_WIDTH     = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * (1 << OFFSET_BITS),
   localparam int unsigned ID_W          = $clog2(NUM_CACHES)
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [NUM_CACHES*BUS_WIDTH-1:0]       cache2mem_data_in,
   input  logic [NUM_CACHES*ADDRESS_WIDTH-1:0]   cache2mem_address_in,
   input  logic [NUM_CACHES*MSG_BITS-1:0]        cache2mem_msg_in,
   output logic [NUM_CACHES*BUS_WIDTH-1:0]       mem2cache_data_out,
   output logic [NUM_CACHES*ADDRESS_WIDTH-1:0]   mem2cache_address_out,
   output logic [NUM_CACHES*MSG_BITS-1:0]        mem2cache_msg_out,
   output logic [MSG_BITS-1:0]                   mem_msg_out,
   output logic [ADDRESS_WIDTH-1:0]              mem_address_out,
   output logic [BUS_WIDTH-1:0]                  mem_data_out,
   input  logic [MSG_BITS-1:0]                   mem_msg_in,
   input  logic [ADDRESS_WIDTH-1:0]              mem_address_in,
   input  logic [BUS_WIDTH-1:0]                  mem_data_in,
   output logic                                  grant_valid,
   output logic [ID_W-1:0]                       grant_id,
   output logic                                  timeout_err
);

   localparam logic [MSG_BITS-1:0] NO_REQ    = MSG_BITS'(0);
   localparam logic [MSG_BITS-1:0] REQ_FLUSH = MSG_BITS'(7);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANTED  = 2'd1,
      ST_RELEASE  = 2'd2
   } state_t;

   state_t                  state;
   logic [ID_W-1:0]         rr_ptr;
   logic [NUM_CACHES-1:0]   req;
   logic [NUM_CACHES-1:0]   eligible;
   logic [NUM_CACHES-1:0]   blocked;
   logic                    pick_found;
   logic [ID_W-1:0]         pick_id;
   logic [ID_W-1:0]         scan_idx;
   logic [MSG_BITS-1:0]     gnt_msg;
   logic                    wd_fire;
   logic                    release_ok;

   // Request detection per channel
   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < NUM_CACHES; i++) begin
         req[i] = (cache2mem_msg_in[i*MSG_BITS +: MSG_BITS] != NO_REQ);
      end
      eligible = req & ~blocked;
   end

   // First eligible requester at or after rr_ptr, wrapping modulo NUM_CACHES
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      scan_idx   = '0;
      for (int unsigned k = 0; k < NUM_CACHES; k++) begin
         scan_idx = ID_W'((32'(rr_ptr) + 32'(k)) % NUM_CACHES);
         if (!pick_found && eligible[scan_idx]) begin
            pick_found = 1'b1;
            pick_id    = scan_idx;
         end
      end
   end

   // Memory port and response routing follow the granted channel only while GRANTED
   always_comb begin
      mem_msg_out           = NO_REQ;
      mem_address_out       = '0;
      mem_data_out          = '0;
      mem2cache_msg_out     = {NUM_CACHES{NO_REQ}};
      mem2cache_address_out = '0;
      mem2cache_data_out    = '0;
      gnt_msg               = NO_REQ;
      for (int unsigned i = 0; i < NUM_CACHES; i++) begin
         if ((state == ST_GRANTED) && (grant_id == ID_W'(i))) begin
            gnt_msg         = cache2mem_msg_in[i*MSG_BITS +: MSG_BITS];
            mem_msg_out     = cache2mem_msg_in[i*MSG_BITS +: MSG_BITS];
            mem_address_out = cache2mem_address_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            mem_data_out    = cache2mem_data_in[i*BUS_WIDTH +: BUS_WIDTH];
            mem2cache_msg_out[i*MSG_BITS +: MSG_BITS]               = mem_msg_in;
            mem2cache_address_out[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = mem_address_in;
            mem2cache_data_out[i*BUS_WIDTH +: BUS_WIDTH]            = mem_data_in;
         end
      end
   end

   // A pending memory REQ_FLUSH keeps the grant so the cache's reply lands on it
   assign release_ok = (gnt_msg == NO_REQ) && (mem_msg_in != REQ_FLUSH);

   // Grant FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         rr_ptr      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state       <= ST_GRANTED;
                  grant_valid <= 1'b1;
                  grant_id    <= pick_id;
                  rr_ptr      <= (pick_id == ID_W'(NUM_CACHES - 1)) ? '0 : ID_W'(pick_id + 1'b1);
               end
            end
            ST_GRANTED: begin
               if (wd_fire || release_ok) begin
                  state       <= ST_RELEASE;
                  grant_valid <= 1'b0;
               end
            end
            ST_RELEASE: begin
               state <= ST_IDLE;
            end
            default: begin
               state       <= ST_IDLE;
               grant_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive GRANTED cycle
   assign wd_fire = (state == ST_GRANTED) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counter, sticky error and stuck-channel lockout
   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
         blocked     <= '0;
      end else begin
         if ((state == ST_IDLE) && pick_found) begin
            wd_cnt <= '0;
         end else if (state == ST_GRANTED) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (wd_fire) begin
            timeout_err <= 1'b1;
         end
         for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            if (wd_fire && (grant_id == ID_W'(i))) begin
               blocked[i] <= 1'b1;
            end else if (!req[i]) begin
               blocked[i] <= 1'b0;
            end
         end
      end
   end
`else
   localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;

   assign wd_fire     = 1'b0;
   assign blocked     = '0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned MSGB = 3;
   localparam int unsigned AW   = 12;
   localparam int unsigned BW   = 36;
   localparam int unsigned TMO  = 8;

   localparam logic [2:0] NO_REQ    = 3'd0;
   localparam logic [2:0] R_REQ     = 3'd1;
   localparam logic [2:0] WB_REQ    = 3'd2;
   localparam logic [2:0] FLUSH     = 3'd3;
   localparam logic [2:0] NO_FLUSH  = 3'd4;
   localparam logic [2:0] MEM_READY = 3'd5;
   localparam logic [2:0] M_RECV    = 3'd6;
   localparam logic [2:0] REQ_FLUSH = 3'd7;

   logic                 clock;
   logic                 reset;
   logic [N*BW-1:0]      c2m_data;
   logic [N*AW-1:0]      c2m_addr;
   logic [N*MSGB-1:0]    c2m_msg;
   logic [N*BW-1:0]      mem2cache_data_out;
   logic [N*AW-1:0]      mem2cache_address_out;
   logic [N*MSGB-1:0]    mem2cache_msg_out;
   logic [MSGB-1:0]      mem_msg_out;
   logic [AW-1:0]        mem_address_out;
   logic [BW-1:0]        mem_data_out;
   logic [MSGB-1:0]      mem_msg_in;
   logic [AW-1:0]        mem_address_in;
   logic [BW-1:0]        mem_data_in;
   logic                 grant_valid;
   logic [1:0]           grant_id;
   logic                 timeout_err;

   logic [MSGB-1:0]      c_msg  [N];
   logic [AW-1:0]        c_addr [N];
   logic [BW-1:0]        c_data [N];

   mem_port_arbiter #(
      .NUM_CACHES     (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .cache2mem_data_in     (c2m_data),
      .cache2mem_address_in  (c2m_addr),
      .cache2mem_msg_in      (c2m_msg),
      .mem2cache_data_out    (mem2cache_data_out),
      .mem2cache_address_out (mem2cache_address_out),
      .mem2cache_msg_out     (mem2cache_msg_out),
      .mem_msg_out           (mem_msg_out),
      .mem_address_out       (mem_address_out),
      .mem_data_out          (mem_data_out),
      .mem_msg_in            (mem_msg_in),
      .mem_address_in        (mem_address_in),
      .mem_data_in           (mem_data_in),
      .grant_valid           (grant_valid),
      .grant_id              (grant_id),
      .timeout_err           (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         c2m_msg[i*MSGB +: MSGB] = c_msg[i];
         c2m_addr[i*AW +: AW]    = c_addr[i];
         c2m_data[i*BW +: BW]    = c_data[i];
      end
   end

   int n_checks;
   int n_errors;

   // Model: who owns the port, whether a turnaround cycle is pending, next scan start
   int m_owner;
   int m_gid;
   int m_ptr;
   int m_wd;
   bit m_rel;
   bit m_terr;
   bit m_valid;
   bit m_blk [N];

   int glog[$];
   bit prev_gv;

   bit a_pend [N];
   int a_hold [N];
   int a_used [N];
   int a_wait [N];

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [MSGB-1:0]   e_msg;
      logic [AW-1:0]     e_addr;
      logic [BW-1:0]     e_data;
      logic [N*MSGB-1:0] e_m2c_msg;
      logic [N*AW-1:0]   e_m2c_addr;
      logic [N*BW-1:0]   e_m2c_data;
      e_msg      = NO_REQ;
      e_addr     = '0;
      e_data     = '0;
      e_m2c_msg  = {N{NO_REQ}};
      e_m2c_addr = '0;
      e_m2c_data = '0;
      if (m_owner >= 0) begin
         e_msg  = c_msg[m_owner];
         e_addr = c_addr[m_owner];
         e_data = c_data[m_owner];
         e_m2c_msg[m_owner*MSGB +: MSGB] = mem_msg_in;
         e_m2c_addr[m_owner*AW +: AW]    = mem_address_in;
         e_m2c_data[m_owner*BW +: BW]    = mem_data_in;
      end
      check("grant_valid", 160'(grant_valid), 160'(m_owner >= 0));
      check("grant_id", 160'(grant_id), 160'(m_gid));
      check("timeout_err", 160'(timeout_err), 160'(m_terr));
      check("mem_msg", 160'(mem_msg_out), 160'(e_msg));
      check("mem_addr", 160'(mem_address_out), 160'(e_addr));
      check("mem_data", 160'(mem_data_out), 160'(e_data));
      check("m2c_msg", 160'(mem2cache_msg_out), 160'(e_m2c_msg));
      check("m2c_addr", 160'(mem2cache_address_out), 160'(e_m2c_addr));
      check("m2c_data", 160'(mem2cache_data_out), 160'(e_m2c_data));
   endtask

   task automatic model_update();
      bit fire;
      bit found;
      int idx;
      fire  = 1'b0;
      found = 1'b0;
      if (reset) begin
         m_owner = -1; m_gid = 0; m_ptr = 0; m_wd = 0;
         m_rel = 0; m_terr = 0; m_valid = 1;
         foreach (m_blk[i]) m_blk[i] = 0;
         return;
      end
      if (!m_valid) return;
`ifdef MEM_ARB_TIMEOUT_EN
      if (m_owner >= 0 && m_wd + 1 == TMO) fire = 1'b1;
`endif
      for (int i = 0; i < N; i++) if (c_msg[i] == NO_REQ) m_blk[i] = 0;
      if (m_owner >= 0) begin
         if (fire) begin
            m_terr = 1; m_blk[m_owner] = 1; m_owner = -1; m_rel = 1;
         end else if (c_msg[m_owner] == NO_REQ && mem_msg_in != REQ_FLUSH) begin
            m_owner = -1; m_rel = 1;
         end else begin
            m_wd++;
         end
      end else if (m_rel) begin
         m_rel = 0;
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && c_msg[idx] != NO_REQ && !m_blk[idx]) begin
               found = 1; m_owner = idx; m_gid = idx; m_ptr = (idx + 1) % N; m_wd = 0;
            end
         end
      end
   endtask

   // One clock: compare outputs mid-cycle, advance the model, wait for the next falling edge
   task automatic step();
      #1;
      if (m_valid) model_check();
      if (grant_valid === 1'b1 && !prev_gv) glog.push_back(int'(grant_id));
      prev_gv = (grant_valid === 1'b1);
      model_update();
      @(negedge clock);
   endtask

   function automatic int pack_log();
      int v;
      v = 0;
      foreach (glog[j]) v = v * 16 + glog[j] + 1;
      return v;
   endfunction

   function automatic logic [2:0] rand_req();
      case ($urandom_range(0, 3))
         0:       return R_REQ;
         1:       return WB_REQ;
         2:       return FLUSH;
         default: return NO_FLUSH;
      endcase
   endfunction

   task automatic agent_start(input int i, input logic [2:0] msg, input int hold);
      a_pend[i] = 1; a_hold[i] = hold; a_used[i] = 0; a_wait[i] = 0;
      c_msg[i]  = msg;
      c_addr[i] = AW'($urandom);
      c_data[i] = BW'({$urandom, $urandom});
   endtask

   // Caches hold a request for a few granted cycles, then drop to NO_REQ
   task automatic agents_drive(input bit rnd);
      for (int i = 0; i < N; i++) begin
         if (a_pend[i]) begin
            if (m_owner == i) begin
               a_used[i]++;
               if (a_used[i] > a_hold[i]) a_pend[i] = 0;
               else if (rnd && $urandom_range(0, 7) == 0) c_msg[i] = rand_req();
            end else begin
               a_wait[i]++;
               if (rnd && a_wait[i] > 40) a_pend[i] = 0;
            end
            if (!a_pend[i]) c_msg[i] = NO_REQ;
         end else if (rnd && $urandom_range(0, 3) == 0) begin
            agent_start(i, rand_req(), int'($urandom_range(1, 5)));
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         a_pend[i] = 0; c_msg[i] = NO_REQ; c_addr[i] = '0; c_data[i] = '0;
      end
      mem_msg_in = NO_REQ; mem_address_in = '0; mem_data_in = '0;
      step();
      reset = 1'b0;
      glog.delete();
   endtask

   initial begin
      n_checks = 0; n_errors = 0; m_valid = 0; m_owner = -1; prev_gv = 0;
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         a_pend[i] = 0; c_msg[i] = NO_REQ; c_addr[i] = '0; c_data[i] = '0;
      end
      mem_msg_in = NO_REQ; mem_address_in = '0; mem_data_in = '0;
      @(negedge clock);
      step();
      step();

      // Reset state, then a single read from cache 2
      check("rst_mem_msg", 160'(mem_msg_out), 160'(NO_REQ));
      check("rst_gv", 160'(grant_valid), 160'(0));
      check("rst_m2c_msg", 160'(mem2cache_msg_out), 160'({N{NO_REQ}}));
      reset = 1'b0;
      c_msg[2] = R_REQ; c_addr[2] = 12'h1A4;
      step();
      check("s1_gid", 160'(grant_id), 160'(2));
      check("s1_addr", 160'(mem_address_out), 160'(12'h1A4));
      check("s1_msg", 160'(mem_msg_out), 160'(R_REQ));
      mem_msg_in = MEM_READY; mem_data_in = 36'hDEADBEEF5; mem_address_in = 12'h1A4;
      #1;
      check("s1_m2c_msg2", 160'(mem2cache_msg_out[8:6]), 160'(MEM_READY));
      check("s1_m2c_msg0", 160'(mem2cache_msg_out[2:0]), 160'(NO_REQ));
      check("s1_m2c_data2", 160'(mem2cache_data_out[2*BW +: BW]), 160'(36'hDEADBEEF5));
      check("s1_m2c_data1", 160'(mem2cache_data_out[BW +: BW]), 160'(0));
      step();
      c_msg[2] = NO_REQ; mem_msg_in = NO_REQ; mem_data_in = '0; mem_address_in = '0;
      repeat (3) step();

      // Fairness: 0, 1, 3 request together
      do_reset();
      agent_start(0, WB_REQ, 2); agent_start(1, WB_REQ, 2); agent_start(3, WB_REQ, 2);
      for (int c = 0; c < 40; c++) begin agents_drive(0); step(); end
      check("s2_order", 160'(pack_log()), 160'(32'h124));

      // Wrap: advance rr_ptr to 3, then 0 and 3 compete, then 1 and 2
      do_reset();
      agent_start(2, R_REQ, 1);
      for (int c = 0; c < 8; c++) begin agents_drive(0); step(); end
      agent_start(0, R_REQ, 1); agent_start(3, R_REQ, 1);
      for (int c = 0; c < 15; c++) begin agents_drive(0); step(); end
      agent_start(1, WB_REQ, 1); agent_start(2, WB_REQ, 1);
      for (int c = 0; c < 15; c++) begin agents_drive(0); step(); end
      check("s3_order", 160'(pack_log()), 160'(32'h34123));

      // Flush hold on cache 1
      do_reset();
      c_msg[1] = R_REQ; c_addr[1] = 12'h3C0;
      step();
      mem_msg_in = REQ_FLUSH; c_msg[1] = NO_REQ;
      step();
      check("s4_gv", 160'(grant_valid), 160'(1));
      check("s4_gid", 160'(grant_id), 160'(1));
      c_msg[1] = FLUSH; mem_msg_in = NO_REQ;
      #1;
      check("s4_flush", 160'(mem_msg_out), 160'(FLUSH));
      step();
      c_msg[1] = NO_REQ;
      repeat (3) step();

      // Reset mid-transaction
      do_reset();
      c_msg[0] = R_REQ;
      step();
      c_msg[3] = WB_REQ;
      step();
      check("s5_gid0", 160'(grant_id), 160'(0));
      reset = 1'b1;
      step();
      check("s5_gv", 160'(grant_valid), 160'(0));
      check("s5_msg", 160'(mem_msg_out), 160'(NO_REQ));
      reset = 1'b0; c_msg[0] = NO_REQ;
      step();
      check("s5_gid3", 160'(grant_id), 160'(3));
      check("s5_gv3", 160'(grant_valid), 160'(1));
      c_msg[3] = NO_REQ;
      repeat (3) step();

      // Memory never answers while caches 0 and 2 both wait
      do_reset();
      c_msg[0] = R_REQ; c_msg[2] = R_REQ;
`ifdef MEM_ARB_TIMEOUT_EN
      repeat (8) step();
      check("s6_hold", 160'(grant_valid), 160'(1));
      check("s6_noerr", 160'(timeout_err), 160'(0));
      step();
      check("s6_rel", 160'(grant_valid), 160'(0));
      check("s6_err", 160'(timeout_err), 160'(1));
      step();
      step();
      check("s6_gid2", 160'(grant_id), 160'(2));
      check("s6_gv2", 160'(grant_valid), 160'(1));
`else
      repeat (30) step();
      check("s6_hold", 160'(grant_valid), 160'(1));
      check("s6_gid0", 160'(grant_id), 160'(0));
      check("s6_noerr", 160'(timeout_err), 160'(0));
`endif
      c_msg[0] = NO_REQ; c_msg[2] = NO_REQ;
      repeat (4) step();

      // Random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 399) == 0);
         case ($urandom_range(0, 9))
            0, 1, 2, 3: mem_msg_in = NO_REQ;
            4, 5:       mem_msg_in = MEM_READY;
            6, 7:       mem_msg_in = M_RECV;
            8:          mem_msg_in = REQ_FLUSH;
            default:    mem_msg_in = NO_REQ;
         endcase
         mem_address_in = AW'($urandom);
         mem_data_in    = BW'({$urandom, $urandom});
         agents_drive(1);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
